// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one synchronous palette-index ROM read port among NUM_REQ
//   requesters. Requester 0 (display pixel stream) has priority; 1..NUM_REQ-1
//   are served round-robin. A starvation counter forces one round-robin grant
//   after MAX_STARVE consecutive priority wins while others pend. Read data
//   returns ROM_LAT cycles after grant, tagged one-hot with the owner.
// Ports:
//   vga_clk, Reset_n      clock, synchronous active-low reset
//   req, addr             per-requester request and packed AW-bit addresses
//   gnt                   one-hot combinational grant (acceptance cycle)
//   rom_addr, rom_rd      ROM read port
//   rom_q                 ROM data, valid ROM_LAT cycles after sample
//   rd_valid, rd_data     one-hot owner tag and returned palette index
//   starve_event          one-cycle pulse after a forced grant
module sprite_rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int AW         = 17,
  parameter int DW         = 4,
  parameter int ROM_LAT    = 1,
  parameter int MAX_STARVE = 8
) (
  input  logic                  vga_clk,
  input  logic                  Reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] addr,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [AW-1:0]         rom_addr,
  output logic                  rom_rd,
  input  logic [DW-1:0]         rom_q,
  output logic [NUM_REQ-1:0]    rd_valid,
  output logic [DW-1:0]         rd_data,
  output logic                  starve_event
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = $clog2(MAX_STARVE + 1);

  logic [NUM_REQ-1:0][AW-1:0] addr_v;
  assign addr_v = addr;

  logic [IW-1:0] rr_ptr;
  logic [SW-1:0] starve_cnt;

  logic              others, starved, gnt_any, forced;
  logic [IW-1:0]     gnt_id;
  logic [IW:0]       cand;

  // {valid, id} return pipeline; stage ROM_LAT-1 lines up with rom_q
  logic [ROM_LAT-1:0]         vld_pipe;
  logic [ROM_LAT-1:0][IW-1:0] id_pipe;

  always_comb begin
    others  = |req[NUM_REQ-1:1];
    starved = (starve_cnt == SW'(MAX_STARVE));
    gnt_any = 1'b0;
    gnt_id  = '0;
    forced  = 1'b0;
    cand    = '0;
    if (Reset_n) begin
      if (req[0] && !(others && starved)) begin
        gnt_any = 1'b1;
      end else if (others) begin
        // Walk from the farthest candidate back to rr_ptr so the one closest
        // to rr_ptr in round-robin order is written last and wins.
        for (int o = NUM_REQ-2; o >= 0; o--) begin
          cand = {1'b0, rr_ptr} + (IW+1)'(o);
          if (cand > (IW+1)'(NUM_REQ-1)) cand = cand - (IW+1)'(NUM_REQ-1);
          if (req[cand[IW-1:0]]) gnt_id = cand[IW-1:0];
        end
        gnt_any = 1'b1;
        // Reaching here with req[0] set means the counter overrode it.
        forced  = req[0];
      end
    end
  end

  assign gnt      = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
  assign rom_addr = gnt_any ? addr_v[gnt_id] : '0;
  assign rom_rd   = gnt_any;

  always_ff @(posedge vga_clk) begin
    if (!Reset_n) begin
      rr_ptr       <= IW'(1);
      starve_cnt   <= '0;
      starve_event <= 1'b0;
      vld_pipe     <= '0;
      id_pipe      <= '0;
    end else begin
      starve_event <= forced;
      if (gnt_any && gnt_id != '0) begin
        rr_ptr     <= (gnt_id == IW'(NUM_REQ-1)) ? IW'(1) : gnt_id + IW'(1);
        starve_cnt <= '0;
      end else if (!others) begin
        starve_cnt <= '0;
      end else if (gnt_any && !starved) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      vld_pipe[0] <= gnt_any;
      id_pipe[0]  <= gnt_id;
      for (int s = 1; s < ROM_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  // Masked by Reset_n so a read granted just before reset never surfaces.
  assign rd_valid = (Reset_n && vld_pipe[ROM_LAT-1]) ?
                    (NUM_REQ'(1) << id_pipe[ROM_LAT-1]) : '0;
  assign rd_data  = (|rd_valid) ? rom_q : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM_LAT=1 and ROM_LAT=3) share
// one stimulus stream; a cycle-level reference model predicts grants, starve
// pulses and tagged read returns from the arbitration rules.
module tb_sprite_rom_arbiter;
  localparam int N = 4, AW = 17, DW = 4, MS = 8, HN = 8192;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic          Reset_n;
  logic [N-1:0]  req;
  logic [N*AW-1:0] addr;

  logic [N-1:0]  gnt1, gnt3, rv1, rv3;
  logic [AW-1:0] ra1, ra3;
  logic          rd1, rd3, se1, se3;
  logic [DW-1:0] rq1, rq3, rdat1, rdat3;
  logic [DW-1:0] r3 [0:2];

  sprite_rom_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(1), .MAX_STARVE(MS)) u_dut1 (
    .vga_clk(vga_clk), .Reset_n(Reset_n), .req(req), .addr(addr), .gnt(gnt1),
    .rom_addr(ra1), .rom_rd(rd1), .rom_q(rq1), .rd_valid(rv1), .rd_data(rdat1),
    .starve_event(se1));

  sprite_rom_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .ROM_LAT(3), .MAX_STARVE(MS)) u_dut3 (
    .vga_clk(vga_clk), .Reset_n(Reset_n), .req(req), .addr(addr), .gnt(gnt3),
    .rom_addr(ra3), .rom_rd(rd3), .rom_q(rq3), .rd_valid(rv3), .rd_data(rdat3),
    .starve_event(se3));

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a ^ (a >> 4) ^ (a >> 9) ^ (a >> 13);
    return t[DW-1:0] ^ 4'h5;
  endfunction

  // ROM models: latency 1 and latency 3
  always @(posedge vga_clk) begin
    rq1   <= rom_fn(ra1);
    r3[0] <= rom_fn(ra3);
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign rq3 = r3[2];

  int n_cmp = 0, n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // reference model state and history
  int rr = 1, sc = 0, last_rst = -1, exp_g;
  int            gh  [0:HN-1];
  logic [AW-1:0] ah  [0:HN-1];
  bit            fh  [0:HN-1];
  logic [N-1:0]  og  [0:HN-1], orv1 [0:HN-1], orv3 [0:HN-1];
  logic [AW-1:0] oa  [0:HN-1];
  logic          ose [0:HN-1];
  logic [DW-1:0] od3 [0:HN-1];

  // Expected return for latency L: the grant made L cycles ago, unless a
  // reset cycle lies between it and now or reset is asserted now.
  task automatic ret_exp(input int L, output logic [N-1:0] v, output logic [DW-1:0] d);
    int g;
    g = cyc - L;
    v = '0; d = '0;
    if (Reset_n && g >= 0 && g > last_rst && gh[g] >= 0) begin
      v = N'(1) << gh[g];
      d = rom_fn(ah[g]);
    end
  endtask

  task automatic cycle();
    int g, idx;
    bit f, oth;
    logic [N-1:0]  ev;
    logic [DW-1:0] ed;
    @(negedge vga_clk);
    oth = |req[N-1:1];
    g = -1; f = 0;
    if (Reset_n) begin
      if (req[0] && !(oth && sc == MS)) g = 0;
      else if (oth) begin
        for (int k = 0; k < N-1; k++) begin
          idx = rr + k;
          if (idx > N-1) idx -= N-1;
          if (req[idx]) begin g = idx; break; end
        end
        f = req[0];
      end
    end
    gh[cyc] = g; fh[cyc] = f;
    ah[cyc] = (g >= 0) ? addr[g*AW +: AW] : '0;
    og[cyc] = gnt1; oa[cyc] = ra1; ose[cyc] = se1;
    orv1[cyc] = rv1; orv3[cyc] = rv3; od3[cyc] = rdat3;
    chk("gnt1", gnt1, (g >= 0) ? (1 << g) : 0);
    chk("gnt3", gnt3, (g >= 0) ? (1 << g) : 0);
    chk("rom_addr1", ra1, ah[cyc]);
    chk("rom_addr3", ra3, ah[cyc]);
    chk("rom_rd1", rd1, g >= 0);
    chk("rom_rd3", rd3, g >= 0);
    if (cyc > 0) begin
      chk("starve1", se1, fh[cyc-1]);
      chk("starve3", se3, fh[cyc-1]);
    end
    ret_exp(1, ev, ed);
    chk("rd_valid1", rv1, ev);
    chk("rd_data1", rdat1, ed);
    ret_exp(3, ev, ed);
    chk("rd_valid3", rv3, ev);
    chk("rd_data3", rdat3, ed);
    exp_g = g;
    @(posedge vga_clk);
    if (!Reset_n) begin rr = 1; sc = 0; last_rst = cyc; end
    else if (g >= 1) begin rr = (g == N-1) ? 1 : g + 1; sc = 0; end
    else if (!oth) sc = 0;
    else if (g == 0 && sc < MS) sc++;
    cyc++;
    #1;
  endtask

  int c0, c1;
  int s2 [6] = '{2, 3, 1, 2, 3, 1};
  bit pend [N];
  logic [AW-1:0] paddr [N];

  initial begin
    Reset_n = 1'b0; req = '0; addr = '0;
    repeat (2) cycle();
    Reset_n = 1'b1;

    // single background request
    addr[2*AW +: AW] = 17'h00ABC;
    req = 4'b0100; c0 = cyc; cycle();
    req = '0; cycle();
    chk("t1_gnt", og[c0], 4'b0100);
    chk("t1_addr", oa[c0], 17'h00ABC);
    chk("t1_rv", orv1[c0+1], 4'b0100);

    // round robin from rr_ptr=2
    req = 4'b0010; cycle();
    req = 4'b1110; c0 = cyc; repeat (6) cycle();
    req = '0; cycle();
    for (int i = 0; i < 6; i++) begin
      chk("t2_seq", og[c0+i], 1 << s2[i]);
      chk("t2_rv", orv1[c0+i+1], 1 << s2[i]);
    end

    // starvation override
    req = 4'b0011; c0 = cyc; repeat (10) cycle();
    req = '0; cycle();
    for (int i = 0; i < 8; i++) chk("t3_pri", og[c0+i], 4'b0001);
    chk("t3_forced", og[c0+8], 4'b0010);
    chk("t3_event", ose[c0+9], 1'b1);
    chk("t3_resume", og[c0+9], 4'b0001);

    // display alone never starves anyone
    req = 4'b0001; c0 = cyc; repeat (20) cycle();
    req = '0; cycle();
    for (int i = 1; i <= 20; i++) chk("t4_event", ose[c0+i], 1'b0);

    // reset flushes an in-flight read
    addr[1*AW +: AW] = 17'h1F00F; addr[2*AW +: AW] = 17'h0C35A; addr[3*AW +: AW] = 17'h12345;
    req = 4'b1000; c0 = cyc; cycle();
    Reset_n = 1'b0; req = 4'b1110; cycle();
    chk("t5_rv_rst", orv1[c0+1], 4'b0000);
    chk("t5_gnt_rst", og[c0+1], 4'b0000);
    Reset_n = 1'b1; c1 = cyc; repeat (3) cycle();
    req = '0; repeat (4) cycle();
    chk("t5_rv_after", orv1[c1], 4'b0000);
    for (int i = 0; i < 3; i++) begin
      chk("t6_gnt", og[c1+i], 4'b0010 << i);
      chk("t6_rv3", orv3[c1+3+i], 4'b0010 << i);
      chk("t6_rd3", od3[c1+3+i], rom_fn(addr[(i+1)*AW +: AW]));
    end

    // randomized traffic: requesters hold req/addr until granted
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (3000) begin
      Reset_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < ((i == 0) ? 85 : 30)) begin
          pend[i] = 1;
          paddr[i] = AW'($urandom);
        end else if (pend[i] && $urandom_range(0, 59) == 0) begin
          pend[i] = 0;
        end
        req[i] = pend[i];
        addr[i*AW +: AW] = paddr[i];
      end
      cycle();
      if (exp_g >= 0) pend[exp_g] = 0;
    end
    req = '0; Reset_n = 1'b1;
    repeat (5) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous palette-index ROM read port among NUM_REQ requesters: the display pixel fetch, the player sprite, the enemy sprites and the HUD overlay.
- Requester 0 is the display pixel stream and has priority. Requesters 1..NUM_REQ-1 are served round-robin.
- A starvation counter guarantees background requesters forward progress.
- Read data returns ROM_LAT cycles after grant, tagged to the granted requester. Output feeds the palette lookup in the colour mappers.

Parameters:
- NUM_REQ, 4, number of requesters; requester 0 is the display stream (min 2).
- AW, 17, ROM address width.
- DW, 4, ROM data width (palette index).
- ROM_LAT, 1, cycles from ROM address sample to rom_q valid (1..4).
- MAX_STARVE, 8, consecutive cycles requester 0 may win while others pend before one forced round-robin grant.

Ports:
- vga_clk  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  request per requester; held with addr until granted.
- addr  in  NUM_REQ*AW  packed addresses; slice i = addr[i*AW +: AW].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as acceptance.
- rom_addr  out  AW  address to ROM, combinational from winning slice.
- rom_rd  out  1  ROM read enable; high iff any gnt bit is high.
- rom_q  in  DW  ROM data, valid ROM_LAT cycles after sample.
- rd_valid  out  NUM_REQ  one-hot, marks rd_data owner.
- rd_data  out  DW  rom_q passed through while any rd_valid is high, else 0.
- starve_event  out  1  registered one-cycle pulse when a forced grant occurs.

Behaviour:
- Reset (Reset_n=0 at edge) clears the following:
  - rr_ptr=1, starve_cnt=0.
  - Valid/id pipeline cleared; rd_valid=0, rd_data=0, starve_event=0.
  - gnt, rom_rd and rom_addr are 0 while Reset_n=0, regardless of req.
- Handshake:
  - A request is accepted in the cycle gnt[i]=1.
  - The requester may change addr or drop req from the next cycle.
  - Dropping req before grant is allowed (no transaction).
  - At most one grant per cycle.
- Arbitration per cycle, with others = any req[1..NUM_REQ-1]:
  - req[0] && !(others && starve_cnt==MAX_STARVE): grant 0.
  - Otherwise, if others: grant the first asserted index searching rr_ptr, rr_ptr+1, ..., wrapping NUM_REQ-1 -> 1.
  - No req: no grant, rom_addr=0.
- rr_ptr update: on a grant to k in 1..NUM_REQ-1, rr_ptr <= (k==NUM_REQ-1) ? 1 : k+1. Unchanged on a grant to 0 or idle.
- starve_cnt:
  - Increments (saturating at MAX_STARVE) on a grant to 0 while others=1.
  - Cleared on any grant to 1..NUM_REQ-1.
  - Cleared on any cycle with others=0.
- starve_event <= 1 in the cycle after a grant to k>=1 made while req[0]=1 and starve_cnt==MAX_STARVE; else 0.
- Return pipeline:
  - A ROM_LAT-deep shift register of {valid, id} loads the grant each cycle.
  - Stage ROM_LAT-1 output drives rd_valid (one-hot decode of id) and rd_data.
  - For ROM_LAT=1: a grant in cycle N gives rd_valid in cycle N+1.
- Back-to-back grants every cycle give back-to-back rd_valid; there is no bubble.
- No backpressure on the return path; requesters must accept rd_data when rd_valid.
- Reset mid-operation flushes in-flight reads: no rd_valid after reset, even for grants issued the cycle before.

Test Plan:
- Reset, then req=4'b0100, addr[2]=17'h00ABC, ROM_LAT=1 -> gnt=4'b0100 and rom_addr=17'h00ABC in the same cycle; next cycle rd_valid=4'b0100, rd_data=rom_q; rr_ptr=3.
- req=4'b1110 held 6 cycles -> grants in order 2,3,1,2,3,1 (starting rr_ptr=2); rd_valid follows one cycle later, each cycle.
- req=4'b0011 held, MAX_STARVE=8 -> grant 0 for 8 cycles, grant 1 on cycle 9, starve_event=1 on cycle 10, grant 0 resumes on cycle 10.
- req=4'b0001 only, 20 cycles -> gnt=4'b0001 every cycle, starve_cnt stays 0, no starve_event.
- Grant issued to requester 3 in cycle N, Reset_n=0 at edge N+1 -> rd_valid=0 in N+1 and after; rr_ptr=1, outputs zero.
- ROM_LAT=3, grants 1,2,3 on consecutive cycles N..N+2 -> rd_valid 4'b0010, 4'b0100, 4'b1000 in cycles N+3..N+5, rd_data matching the ROM model per address.
